inst_fetch_bridge: RTL
======================

INST_FETCH_BRIDGE -- requirements
Module: inst_fetch_bridge

Interface
REQ-001 Parameter: ALIGN_CHECK, default 1, meaning 1 = misaligned fetch address raises address-error instead of issuing a bus request.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 pc  in  1  fetch request valid from PC stage.
REQ-005 pc_addr  in  32  fetch address.
REQ-006 flush  in  1  redirect (exception/branch); discard current fetch.
REQ-007 id_ready  in  1  decode stage accepts the held instruction.
REQ-008 inst_req  out  1  SRAM-like instruction bus request.
REQ-009 inst_addr  out  32  bus request address.
REQ-010 inst_addr_ok  in  1  bus accepted the request.
REQ-011 inst_data_ok  in  1  bus read data valid.
REQ-012 inst_rdata  in  32  bus read data.
REQ-013 inst_valid  out  1  instruction held for decode.
REQ-014 inst  out  32  instruction word.
REQ-015 inst_pc  out  32  address of inst.
REQ-016 inst_adel  out  1  instruction-fetch address error.
REQ-017 fetch_stall  out  1  PC must hold; combinational from state and id_ready.

Function
REQ-018 FSM states: IDLE, REQ, WAIT, VALID; discard flag drop tracks in-flight fetches to discard.
REQ-019 Accept = pc & ~fetch_stall & ~flush; accept only occurs in IDLE or in VALID with id_ready=1.
REQ-020 On accept with aligned pc_addr (or ALIGN_CHECK=0): latch inst_addr=pc_addr, inst_pc=pc_addr; next state REQ.
REQ-021 On accept with pc_addr[1:0]!=0 and ALIGN_CHECK=1: no bus request; next state VALID with inst=0, inst_adel=1, inst_pc=pc_addr.
REQ-022 REQ: inst_req=1, inst_addr stable; on inst_addr_ok -> WAIT; inst_req and inst_addr are never withdrawn or changed before inst_addr_ok, flush notwithstanding.
REQ-023 WAIT: on inst_data_ok with drop=0 -> VALID with inst=inst_rdata, inst_adel=0; with drop=1 -> IDLE, drop cleared, data discarded.
REQ-024 VALID: inst_valid=1; inst, inst_pc, inst_adel stable while id_ready=0; on id_ready=1 -> IDLE, or REQ/VALID if a new accept occurs in the same cycle.
REQ-025 fetch_stall=1 in REQ, in WAIT, and in VALID while id_ready=0; 0 otherwise.
REQ-026 flush in IDLE: no accept that cycle.
REQ-027 flush in REQ or WAIT: set drop=1; bus transaction completes, response discarded; flush coincident with inst_addr_ok or inst_data_ok is handled identically.
REQ-028 flush in VALID: inst_valid cleared next cycle, next state IDLE, no accept that cycle.
REQ-029 inst_data_ok outside WAIT and inst_addr_ok outside REQ are ignored.
REQ-030 At most one outstanding bus transaction at any time.
REQ-031 inst_valid, inst, inst_pc, inst_adel, inst_req, and inst_addr are registered outputs.

Reset
REQ-032 rst=1 forces asynchronously: state IDLE, drop=0, inst_req=0, inst_addr=0, inst_valid=0, inst=0, inst_pc=0, inst_adel=0; fetch_stall=0.
REQ-033 Reset asserted mid-transaction abandons it; responses arriving after reset release are ignored per REQ-029.

Verification
REQ-034 Zero-wait fetch: pc=1, pc_addr=0xbfc00000, inst_addr_ok in first REQ cycle, inst_data_ok next cycle with inst_rdata=0x24080001 -> inst_req high exactly 1 cycle with inst_addr=0xbfc00000; next cycle inst_valid=1, inst=0x24080001, inst_pc=0xbfc00000.
REQ-035 Backpressure: in VALID, id_ready=0 for 3 cycles -> inst/inst_pc unchanged, fetch_stall=1, inst_req=0; id_ready=1 with pc=1, pc_addr=0xbfc00004 -> REQ next cycle with inst_addr=0xbfc00004.
REQ-036 Flush in REQ: inst_addr_ok held low 2 cycles, flush pulses in the first -> inst_req stays 1 with same address until inst_addr_ok; subsequent data discarded, inst_valid never 1, IDLE after inst_data_ok; then fetch of 0xbfc00380 proceeds normally.
REQ-037 Flush coincident with inst_data_ok in WAIT -> inst_valid stays 0, IDLE next cycle.
REQ-038 Misaligned: pc_addr=0xbfc00002 -> inst_req never asserted; next cycle inst_valid=1, inst_adel=1, inst=0, inst_pc=0xbfc00002.
REQ-039 Async reset in WAIT, no clock edge -> all outputs 0 immediately; a stray inst_data_ok after release produces no inst_valid.

Source files
------------

// File: rtl/inst_fetch_bridge.sv
// Instruction fetch bridge between the PC stage, an SRAM-like instruction bus,
// and the decode stage. At most one bus transaction is ever outstanding; fetches
// redirected by flush while on the bus still run to completion, and their
// response is dropped.
module inst_fetch_bridge #(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc,
    input  logic [31:0] pc_addr,
    input  logic        flush,
    input  logic        id_ready,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_adel,
    output logic        fetch_stall
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        VALID = 2'd3
    } state_t;

    state_t            state, state_n;
    logic              drop, drop_n;
    logic              req_n;
    logic [XLEN-1:0]   addr_n;
    logic              valid_n;
    logic [XLEN-1:0]   inst_n;
    logic [XLEN-1:0]   pc_n;
    logic              adel_n;
    logic              accept;
    logic              misaligned;

    // PC must hold while the bus is busy or decode has not taken the held word
    assign fetch_stall = (state == REQ) || (state == WAIT) ||
                         ((state == VALID) && !id_ready);

    assign accept     = pc && !fetch_stall && !flush;
    assign misaligned = ALIGN_CHECK && (pc_addr[1:0] != 2'b00);

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            drop       <= 1'b0;
            inst_req   <= 1'b0;
            inst_addr  <= '0;
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
            inst_adel  <= 1'b0;
        end else begin
            state      <= state_n;
            drop       <= drop_n;
            inst_req   <= req_n;
            inst_addr  <= addr_n;
            inst_valid <= valid_n;
            inst       <= inst_n;
            inst_pc    <= pc_n;
            inst_adel  <= adel_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n = state;
        drop_n  = drop;
        req_n   = inst_req;
        addr_n  = inst_addr;
        valid_n = inst_valid;
        inst_n  = inst;
        pc_n    = inst_pc;
        adel_n  = inst_adel;

        unique case (state)
            IDLE, VALID: begin
                // Leaving VALID: on flush, or when decode takes the word
                if (state == VALID && (flush || id_ready)) begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                end
                // A new fetch may start in the same cycle the old word is consumed
                if (accept) begin
                    pc_n = pc_addr;
                    if (misaligned) begin
                        state_n = VALID;
                        valid_n = 1'b1;
                        inst_n  = '0;
                        adel_n  = 1'b1;
                        req_n   = 1'b0;
                    end else begin
                        state_n = REQ;
                        req_n   = 1'b1;
                        addr_n  = pc_addr;
                        valid_n = 1'b0;
                        adel_n  = 1'b0;
                    end
                end
            end
            REQ: begin
                // Request stays up until accepted; flush only marks it for discard
                if (flush) drop_n = 1'b1;
                if (inst_addr_ok) begin
                    req_n   = 1'b0;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (flush) drop_n = 1'b1;
                if (inst_data_ok) begin
                    if (drop || flush) begin
                        state_n = IDLE;
                        drop_n  = 1'b0;
                    end else begin
                        state_n = VALID;
                        valid_n = 1'b1;
                        inst_n  = inst_rdata;
                        adel_n  = 1'b0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
